// File: rtl/dsp_line_stats.sv
// Per-scanline audio statistics: min, max, truncated mean and sample count of the audio
// samples received between successive HSync falling edges, computed with a serial divider.
module dsp_line_stats #(
  parameter int WS    = 16,
  parameter int CNT_W = 8,
  localparam int SUM_W = WS + CNT_W
) (
  input  logic             iCLK_50,
  input  logic             iRST,
  input  logic             iLRCK,
  input  logic             iHS,
  input  logic [WS-1:0]    iSample,
  output logic [WS-1:0]    oMin,
  output logic [WS-1:0]    oMax,
  output logic [WS-1:0]    oAvg,
  output logic [CNT_W-1:0] oCount,
  output logic             oValid,
  output logic             oOverrun
);

  localparam int BW = $clog2(SUM_W);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [BW-1:0]    LAST_BIT = BW'(SUM_W - 1);

  typedef enum logic [1:0] {ST_ACC, ST_DIV, ST_OUT} state_e;

  // Synchronisers: [0],[1] are the 2-FF chain, [2] is the edge-detect register.
  logic [2:0] lrck_sync_q, lrck_sync_d;
  logic [2:0] hs_sync_q, hs_sync_d;
  logic       lrck_rise, hs_fall;

  // Running accumulators for the open window.
  logic signed [SUM_W-1:0] sum_q, sum_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic signed [WS-1:0]    min_q, min_d, max_q, max_d;
  logic                    sat_q, sat_d;
  logic                    drop_q, drop_d;

  // Snapshot of the closed window and the serial divider.
  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        w_cnt_q, w_cnt_d;
  logic [WS-1:0]           w_min_q, w_min_d, w_max_q, w_max_d;
  logic                    w_ovr_q, w_ovr_d;
  logic                    w_neg_q, w_neg_d;
  logic [SUM_W-1:0]        dq_q, dq_d;
  logic [CNT_W-1:0]        rem_q, rem_d;
  logic [BW-1:0]           bit_cnt_q, bit_cnt_d;

  // Registered outputs.
  logic [WS-1:0]           o_min_q, o_min_d, o_max_q, o_max_d, o_avg_q, o_avg_d;
  logic [CNT_W-1:0]        o_count_q, o_count_d;
  logic                    o_valid_q, o_valid_d;
  logic                    o_ovr_q, o_ovr_d;

  // Combinational temporaries.
  logic [SUM_W-1:0]        sample_ext;
  logic signed [SUM_W-1:0] sum_base;
  logic [CNT_W-1:0]        cnt_base;
  logic signed [WS-1:0]    min_base, max_base, sample_s;
  logic                    sat_base;
  logic [CNT_W:0]          rem_shift, divisor_ext;
  logic                    q_bit;
  logic [WS-1:0]           quot_mag;

  assign lrck_rise = lrck_sync_q[1] & ~lrck_sync_q[2];
  assign hs_fall   = ~hs_sync_q[1] & hs_sync_q[2];

  always_comb begin
    lrck_sync_d = {lrck_sync_q[1:0], iLRCK};
    hs_sync_d   = {hs_sync_q[1:0], iHS};
  end

  // A close and a sample in the same cycle: clear first, then the sample opens the new window.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    sample_ext = {{CNT_W{iSample[WS-1]}}, iSample};
    sample_s   = $signed(iSample);
    sum_base   = hs_fall ? '0 : sum_q;
    cnt_base   = hs_fall ? '0 : cnt_q;
    min_base   = hs_fall ? '0 : min_q;
    max_base   = hs_fall ? '0 : max_q;
    sat_base   = hs_fall ? 1'b0 : sat_q;
    sum_d      = sum_base;
    cnt_d      = cnt_base;
    min_d      = min_base;
    max_d      = max_base;
    sat_d      = sat_base;
    if (lrck_rise) begin
      if (cnt_base != CNT_MAX) begin
        sum_d = sum_base + $signed(sample_ext);
        cnt_d = cnt_base + CNT_W'(1);
        if (cnt_base == '0 || sample_s < min_base) min_d = sample_s;
        if (cnt_base == '0 || sample_s > max_base) max_d = sample_s;
      end else begin
        sat_d = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    w_cnt_d     = w_cnt_q;
    w_min_d     = w_min_q;
    w_max_d     = w_max_q;
    w_ovr_d     = w_ovr_q;
    w_neg_d     = w_neg_q;
    dq_d        = dq_q;
    rem_d       = rem_q;
    bit_cnt_d   = bit_cnt_q;
    drop_d      = drop_q;
    o_min_d     = o_min_q;
    o_max_d     = o_max_q;
    o_avg_d     = o_avg_q;
    o_count_d   = o_count_q;
    o_ovr_d     = o_ovr_q;
    o_valid_d   = 1'b0;
    rem_shift   = {rem_q, dq_q[SUM_W-1]};
    divisor_ext = {1'b0, w_cnt_q};
    q_bit       = 1'b0;
    quot_mag    = '0;

    case (state_q)
      ST_ACC: begin
        if (hs_fall) begin
          state_d   = ST_DIV;
          w_cnt_d   = cnt_q;
          w_min_d   = min_q;
          w_max_d   = max_q;
          w_ovr_d   = sat_q | drop_q;
          drop_d    = 1'b0;
          w_neg_d   = sum_q[SUM_W-1];
          dq_d      = sum_q[SUM_W-1] ? -sum_q : sum_q;
          rem_d     = '0;
          bit_cnt_d = '0;
        end
      end
      ST_DIV: begin
        if (hs_fall) drop_d = 1'b1;
        // Restoring step: dq shifts dividend bits out the top and quotient bits in the bottom.
        if (rem_shift >= divisor_ext) begin
          q_bit = 1'b1;
          rem_d = CNT_W'(rem_shift - divisor_ext);
        end else begin
          rem_d = CNT_W'(rem_shift);
        end
        dq_d      = {dq_q[SUM_W-2:0], q_bit};
        bit_cnt_d = bit_cnt_q + BW'(1);
        if (bit_cnt_q == LAST_BIT) begin
          state_d   = ST_OUT;
          o_valid_d = 1'b1;
          o_count_d = w_cnt_q;
          o_ovr_d   = (w_cnt_q != '0) & w_ovr_q;
          if (w_cnt_q != '0) begin
            quot_mag = dq_d[WS-1:0];
            o_min_d  = w_min_q;
            o_max_d  = w_max_q;
            o_avg_d  = w_neg_q ? -quot_mag : quot_mag;
          end
        end
      end
      ST_OUT: begin
        if (hs_fall) drop_d = 1'b1;
        state_d = ST_ACC;
      end
      default: state_d = ST_ACC;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge iCLK_50 or posedge iRST) begin
    if (iRST) begin
      lrck_sync_q <= '0;
      hs_sync_q   <= '1;
      sum_q       <= '0;
      cnt_q       <= '0;
      min_q       <= '0;
      max_q       <= '0;
      sat_q       <= 1'b0;
      drop_q      <= 1'b0;
      state_q     <= ST_ACC;
      w_cnt_q     <= '0;
      w_min_q     <= '0;
      w_max_q     <= '0;
      w_ovr_q     <= 1'b0;
      w_neg_q     <= 1'b0;
      dq_q        <= '0;
      rem_q       <= '0;
      bit_cnt_q   <= '0;
      o_min_q     <= '0;
      o_max_q     <= '0;
      o_avg_q     <= '0;
      o_count_q   <= '0;
      o_valid_q   <= 1'b0;
      o_ovr_q     <= 1'b0;
    end else begin
      lrck_sync_q <= lrck_sync_d;
      hs_sync_q   <= hs_sync_d;
      sum_q       <= sum_d;
      cnt_q       <= cnt_d;
      min_q       <= min_d;
      max_q       <= max_d;
      sat_q       <= sat_d;
      drop_q      <= drop_d;
      state_q     <= state_d;
      w_cnt_q     <= w_cnt_d;
      w_min_q     <= w_min_d;
      w_max_q     <= w_max_d;
      w_ovr_q     <= w_ovr_d;
      w_neg_q     <= w_neg_d;
      dq_q        <= dq_d;
      rem_q       <= rem_d;
      bit_cnt_q   <= bit_cnt_d;
      o_min_q     <= o_min_d;
      o_max_q     <= o_max_d;
      o_avg_q     <= o_avg_d;
      o_count_q   <= o_count_d;
      o_valid_q   <= o_valid_d;
      o_ovr_q     <= o_ovr_d;
    end
  end

  assign oMin     = o_min_q;
  assign oMax     = o_max_q;
  assign oAvg     = o_avg_q;
  assign oCount   = o_count_q;
  assign oValid   = o_valid_q;
  assign oOverrun = o_ovr_q;

endmodule

// File: tb/tb_dsp_line_stats.sv
// Directed bench for dsp_line_stats: expected window statistics are queued when a window is
// closed and compared when oValid pulses; latency, reset abort and overrun paths are covered.
module tb_dsp_line_stats;

  logic               clk;
  logic               rst;
  logic               lrck;
  logic               hs;
  logic signed [15:0] sample;
  logic signed [15:0] o_min, o_max, o_avg;
  logic [7:0]         o_count;
  logic               o_valid, o_overrun;

  typedef struct {
    logic signed [15:0] mn;
    logic signed [15:0] mx;
    logic signed [15:0] avg;
    logic [7:0]         cnt;
    logic               ovr;
  } exp_t;

  exp_t exp_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   n_valid_seen = 0;

  dsp_line_stats #(.WS(16), .CNT_W(8)) dut (
    .iCLK_50 (clk),
    .iRST    (rst),
    .iLRCK   (lrck),
    .iHS     (hs),
    .iSample (sample),
    .oMin    (o_min),
    .oMax    (o_max),
    .oAvg    (o_avg),
    .oCount  (o_count),
    .oValid  (o_valid),
    .oOverrun(o_overrun)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] observed,
                       input logic signed [31:0] expected);
    n_assert++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Scoreboard consumer: every oValid pulse pops one expected window result.
  always @(negedge clk) begin
    if (o_valid === 1'b1) begin
      n_valid_seen++;
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("min",     o_min,           e.mn);
        check("max",     o_max,           e.mx);
        check("avg",     o_avg,           e.avg);
        check("count",   {24'd0, o_count}, {24'd0, e.cnt});
        check("overrun", {31'd0, o_overrun}, {31'd0, e.ovr});
      end
    end
  end

  task automatic send_sample(input logic signed [15:0] s);
    @(negedge clk);
    sample = s;
    lrck   = 1'b1;
    repeat (4) @(negedge clk);
    lrck = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // Closes the open window and checks oValid pulses once, exactly 27 negedges after HS falls.
  task automatic close_window(input logic signed [15:0] emn, input logic signed [15:0] emx,
                              input logic signed [15:0] eavg, input logic [7:0] ecnt,
                              input logic eovr, input bit lrck_too,
                              input logic signed [15:0] lsample, input bit extra_hs);
    exp_t e;
    int   valid_k;
    int   n_valid;
    e.mn = emn; e.mx = emx; e.avg = eavg; e.cnt = ecnt; e.ovr = eovr;
    exp_q.push_back(e);
    valid_k = -1;
    n_valid = 0;
    @(negedge clk);
    hs = 1'b0;
    if (lrck_too) begin
      sample = lsample;
      lrck   = 1'b1;
    end
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      if (k == 4) begin
        hs   = 1'b1;
        lrck = 1'b0;
      end
      if (extra_hs && k == 8)  hs = 1'b0;
      if (extra_hs && k == 12) hs = 1'b1;
      if (o_valid === 1'b1) begin
        n_valid++;
        if (valid_k < 0) valid_k = k;
      end
    end
    check("valid_pulses", n_valid, 1);
    check("valid_latency", valid_k, 27);
    check("scoreboard_drained", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    int seen_before;
    rst    = 1'b1;
    lrck   = 1'b0;
    hs     = 1'b1;
    sample = '0;
    repeat (3) @(negedge clk);
    check("rst_min",   o_min,   0);
    check("rst_max",   o_max,   0);
    check("rst_avg",   o_avg,   0);
    check("rst_count", {24'd0, o_count}, 0);
    check("rst_valid", {31'd0, o_valid}, 0);
    check("rst_ovr",   {31'd0, o_overrun}, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Basic window.
    send_sample(16'sd100);
    send_sample(-16'sd50);
    send_sample(16'sd300);
    send_sample(16'sd2);
    close_window(-16'sd50, 16'sd300, 16'sd88, 8'd4, 1'b0, 1'b0, 16'sd0, 1'b0);

    // Full-scale extremes: no accumulator overflow, mean truncates to 0.
    send_sample(-16'sd32768);
    send_sample(16'sd32767);
    close_window(-16'sd32768, 16'sd32767, 16'sd0, 8'd2, 1'b0, 1'b0, 16'sd0, 1'b0);

    // Negative mean truncates toward zero.
    send_sample(-16'sd7);
    send_sample(-16'sd8);
    close_window(-16'sd8, -16'sd7, -16'sd7, 8'd2, 1'b0, 1'b0, 16'sd0, 1'b0);

    // Empty window holds min/max/avg and reports zero count.
    close_window(-16'sd8, -16'sd7, -16'sd7, 8'd0, 1'b0, 1'b0, 16'sd0, 1'b0);

    // Counter saturation, then a clean window.
    for (int i = 0; i < 300; i++) send_sample(16'sd1000);
    close_window(16'sd1000, 16'sd1000, 16'sd1000, 8'd255, 1'b1, 1'b0, 16'sd0, 1'b0);
    send_sample(16'sd10);
    send_sample(16'sd20);
    close_window(16'sd10, 16'sd20, 16'sd15, 8'd2, 1'b0, 1'b0, 16'sd0, 1'b0);

    // Sample arriving in the closing cycle belongs to the next window.
    send_sample(16'sd40);
    send_sample(16'sd60);
    close_window(16'sd40, 16'sd60, 16'sd50, 8'd2, 1'b0, 1'b1, 16'sd500, 1'b0);
    close_window(16'sd500, 16'sd500, 16'sd500, 8'd1, 1'b0, 1'b0, 16'sd0, 1'b0);

    // Reset ten cycles into the divide: outputs clear, no pulse follows.
    send_sample(16'sd7);
    send_sample(16'sd9);
    seen_before = n_valid_seen;
    @(negedge clk);
    hs = 1'b0;
    repeat (4) @(negedge clk);
    hs = 1'b1;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_min",   o_min,   0);
    check("abort_max",   o_max,   0);
    check("abort_avg",   o_avg,   0);
    check("abort_count", {24'd0, o_count}, 0);
    check("abort_ovr",   {31'd0, o_overrun}, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check("abort_no_valid", n_valid_seen - seen_before, 0);

    send_sample(16'sd5);
    send_sample(16'sd6);
    send_sample(-16'sd4);
    close_window(-16'sd4, 16'sd6, 16'sd2, 8'd3, 1'b0, 1'b0, 16'sd0, 1'b0);

    // Close during the divide drops that window and flags the next report.
    send_sample(16'sd100);
    send_sample(16'sd200);
    close_window(16'sd100, 16'sd200, 16'sd150, 8'd2, 1'b0, 1'b0, 16'sd0, 1'b1);
    send_sample(16'sd1);
    send_sample(16'sd3);
    close_window(16'sd1, 16'sd3, 16'sd2, 8'd2, 1'b1, 1'b0, 16'sd0, 1'b0);
    send_sample(16'sd8);
    close_window(16'sd8, 16'sd8, 16'sd8, 8'd1, 1'b0, 1'b0, 16'sd0, 1'b0);

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
